// File: rtl/emmc_clk_pkg.sv
// Shared definitions for the eMMC card-clock configuration sequencer:
// state encoding, output reset values, phase field layout and the shadow payload.
package emmc_clk_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_STOP   = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_STOP   = ST_STOP,
    S_LOAD   = ST_LOAD,
    S_START  = ST_START,
    S_SETTLE = ST_SETTLE,
    S_DONE   = ST_DONE
  } state_e;

  localparam logic [1:0] MUX_RST   = 2'd0;
  localparam logic [6:0] PHASE_RST = 7'd0;

  // Phase word: [3:0] fine shift, [6:4] delay-line tap.
  localparam int PH_SHIFT_LSB = 0;
  localparam int PH_SHIFT_W   = 4;
  localparam int PH_DLY_LSB   = 4;
  localparam int PH_DLY_W     = 3;

  typedef struct packed {
    logic [1:0] mux;
    logic [6:0] drv;
    logic [6:0] smpl;
    logic       clk_on;
  } clk_cfg_t;

  localparam clk_cfg_t CFG_RST = '{mux: MUX_RST, drv: PHASE_RST, smpl: PHASE_RST, clk_on: 1'b0};

  function automatic logic [6:0] phase_pack(input logic [3:0] shift, input logic [2:0] dly);
    logic [6:0] p;
    p = PHASE_RST;
    p[PH_SHIFT_LSB +: PH_SHIFT_W] = shift;
    p[PH_DLY_LSB +: PH_DLY_W]     = dly;
    return p;
  endfunction

endpackage

// File: rtl/emmc_clk_cfg_seq_if.sv
// Host-request and clock-generator control bundle of the card-clock sequencer.
interface emmc_clk_cfg_seq_if;
  logic       cfg_req;
  logic [1:0] cfg_mux_ctrl;
  logic [6:0] cfg_drv_phase;
  logic [6:0] cfg_smpl_phase;
  logic       cfg_clk_on;
  logic       clk_ready;
  logic [1:0] ext_clk_mux_ctrl;
  logic [6:0] clk_drv_phase_ctrl;
  logic [6:0] clk_smpl_phase_ctrl;
  logic       clk_enable;
  logic       busy;
  logic       cfg_ack;
  logic       cfg_err;

  // Register file plus clock generator side.
  modport master (
    output cfg_req, cfg_mux_ctrl, cfg_drv_phase, cfg_smpl_phase, cfg_clk_on, clk_ready,
    input  ext_clk_mux_ctrl, clk_drv_phase_ctrl, clk_smpl_phase_ctrl, clk_enable,
           busy, cfg_ack, cfg_err
  );

  // Sequencer side.
  modport slave (
    input  cfg_req, cfg_mux_ctrl, cfg_drv_phase, cfg_smpl_phase, cfg_clk_on, clk_ready,
    output ext_clk_mux_ctrl, clk_drv_phase_ctrl, clk_smpl_phase_ctrl, clk_enable,
           busy, cfg_ack, cfg_err
  );
endinterface

// File: rtl/emmc_seq_timer.sv
// Loadable up-counter with clear and a count >= threshold flag, shared by the
// STOP, START and SETTLE phases of the sequencer.
module emmc_seq_timer #(
  parameter int CNT_W = 10
) (
  input  logic             ext_clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  input  logic [CNT_W-1:0] thresh,
  output logic [CNT_W-1:0] cnt,
  output logic             hit
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (ld)  cnt_d = ld_val;
    if (clr) cnt_d = '0;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge ext_clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign hit = (cnt_q >= thresh);

endmodule

// File: rtl/emmc_clk_cfg_seq.sv
// Glitch-free reconfiguration of the eMMC card-clock generator: stop the clock,
// wait for it to gate, load divider/phase, optionally restart and settle.
module emmc_clk_cfg_seq
  import emmc_clk_pkg::*;
#(
  parameter int SYNC_GUARD  = 8,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1023,
  parameter int CNT_W       = 10
) (
  input  logic                 ext_clk,
  input  logic                 rst_n,
  emmc_clk_cfg_seq_if.slave    bus
);

  localparam logic [CNT_W-1:0] GUARD_TH  = CNT_W'(SYNC_GUARD - 1);
  localparam logic [CNT_W-1:0] SETTLE_TH = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TOUT_TH   = CNT_W'(TIMEOUT_CYC - 1);

  state_e     state_q, state_d;
  clk_cfg_t   shadow_q, shadow_d;
  logic [1:0] mux_q, mux_d;
  logic [6:0] drv_q, drv_d;
  logic [6:0] smpl_q, smpl_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;

  logic             tmr_clr, tmr_ld, tmr_hit;
  logic [CNT_W-1:0] tmr_th, tmr_cnt;

  emmc_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .ext_clk (ext_clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .ld      (tmr_ld),
    .ld_val  (CNT_W'(1)),
    .thresh  (tmr_th),
    .cnt     (tmr_cnt),
    .hit     (tmr_hit)
  );

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    mux_d    = mux_q;
    drv_d    = drv_q;
    smpl_d   = smpl_q;
    en_d     = en_q;
    err_d    = 1'b0;
    tmr_clr  = 1'b0;
    tmr_ld   = 1'b0;
    tmr_th   = (state_q == S_SETTLE) ? SETTLE_TH : GUARD_TH;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cfg_req) begin
          shadow_d = '{mux: bus.cfg_mux_ctrl, drv: bus.cfg_drv_phase,
                       smpl: bus.cfg_smpl_phase, clk_on: bus.cfg_clk_on};
          en_d     = 1'b0;
          tmr_clr  = 1'b1;
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (tmr_hit && !bus.clk_ready) begin
          state_d = S_LOAD;
        end else if (tmr_cnt >= TOUT_TH) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_LOAD: begin
        mux_d  = shadow_q.mux;
        drv_d  = shadow_q.drv;
        smpl_d = shadow_q.smpl;
        if (shadow_q.clk_on) begin
          en_d    = 1'b1;
          tmr_clr = 1'b1;
          state_d = S_START;
        end else begin
          state_d = S_DONE;
        end
      end
      S_START: begin
        // Ready is tested first so it wins over a coincident timeout. The
        // qualifying START cycle is the first settle cycle, hence load of 1.
        if (tmr_hit && bus.clk_ready) begin
          tmr_ld  = 1'b1;
          state_d = (SETTLE_CYC == 1) ? S_DONE : S_SETTLE;
        end else if (tmr_cnt >= TOUT_TH) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_SETTLE: begin
        if (tmr_hit) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ack_d  = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge ext_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shadow_q <= CFG_RST;
      mux_q    <= MUX_RST;
      drv_q    <= PHASE_RST;
      smpl_q   <= PHASE_RST;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      mux_q    <= mux_d;
      drv_q    <= drv_d;
      smpl_q   <= smpl_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign bus.ext_clk_mux_ctrl    = mux_q;
  assign bus.clk_drv_phase_ctrl  = drv_q;
  assign bus.clk_smpl_phase_ctrl = smpl_q;
  assign bus.clk_enable          = en_q;
  assign bus.busy                = busy_q;
  assign bus.cfg_ack             = ack_q;
  assign bus.cfg_err             = err_q;

endmodule

// File: tb/tb_emmc_clk_cfg_seq.sv
// Directed bench for emmc_clk_cfg_seq with a delay-line model of the clock
// generator's ready response and overrides for stuck-ready scenarios.
module tb_emmc_clk_cfg_seq;
  import emmc_clk_pkg::*;

  logic ext_clk = 1'b0;
  logic rst_n   = 1'b0;

  emmc_clk_cfg_seq_if bus ();

  emmc_clk_cfg_seq #(
    .SYNC_GUARD (8),
    .SETTLE_CYC (16),
    .TIMEOUT_CYC(1023),
    .CNT_W      (10)
  ) dut (
    .ext_clk (ext_clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  always #5 ext_clk = ~ext_clk;

  // Generator model: clk_ready follows clk_enable through a tap of a delay line.
  logic [15:0] gen_sr   = '0;
  int          gen_tap  = 4;
  logic        force_hi = 1'b0;
  logic        force_lo = 1'b0;

  always @(posedge ext_clk) gen_sr <= {gen_sr[14:0], bus.clk_enable};

  always_comb bus.clk_ready = force_hi | (~force_lo & gen_sr[gen_tap]);

  int ack_cnt = 0;
  always @(negedge ext_clk) if (bus.cfg_ack === 1'b1) ack_cnt++;

  int n_checks = 0;
  int n_errors = 0;
  int ack_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge ext_clk);
    #1;
  endtask

  task automatic check_cfg(input string tag, input logic [1:0] mux, input logic [6:0] drv,
                           input logic [6:0] smpl);
    check({tag, "_mux"},  32'(bus.ext_clk_mux_ctrl),    32'(mux));
    check({tag, "_drv"},  32'(bus.clk_drv_phase_ctrl),  32'(drv));
    check({tag, "_smpl"}, 32'(bus.clk_smpl_phase_ctrl), 32'(smpl));
  endtask

  // Request sampled at the edge inside this task; returns in cycle T+1.
  task automatic send(input logic [1:0] mux, input logic [6:0] drv, input logic [6:0] smpl,
                      input logic on);
    bus.cfg_mux_ctrl   = mux;
    bus.cfg_drv_phase  = drv;
    bus.cfg_smpl_phase = smpl;
    bus.cfg_clk_on     = on;
    bus.cfg_req        = 1'b1;
    tick();
    bus.cfg_req        = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_cfg(tag, 2'd0, 7'h00, 7'h00);
    check({tag, "_en"},   32'(bus.clk_enable), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy),       32'd0);
    check({tag, "_ack"},  32'(bus.cfg_ack),    32'd0);
    check({tag, "_err"},  32'(bus.cfg_err),    32'd0);
  endtask

  initial begin
    bus.cfg_req        = 1'b0;
    bus.cfg_mux_ctrl   = 2'd0;
    bus.cfg_drv_phase  = 7'h00;
    bus.cfg_smpl_phase = 7'h00;
    bus.cfg_clk_on     = 1'b0;

    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // Clock off, no restart: load visible with ack at T+10.
    send(2'd2, phase_pack(4'h3, 3'd0), phase_pack(4'h5, 3'd0), 1'b0);
    check("off_busy_t1", 32'(bus.busy), 32'd1);
    check("off_en_t1",   32'(bus.clk_enable), 32'd0);
    tick(8);
    check_cfg("off_t9", 2'd0, 7'h00, 7'h00);
    check("off_ack_t9", 32'(bus.cfg_ack), 32'd0);
    tick();
    check("off_ack_t10", 32'(bus.cfg_ack), 32'd1);
    check("off_err_t10", 32'(bus.cfg_err), 32'd0);
    check("off_en_t10",  32'(bus.clk_enable), 32'd0);
    check_cfg("off_t10", 2'd2, 7'h03, 7'h05);
    tick();
    check("off_busy_t11", 32'(bus.busy), 32'd0);
    check("off_ack_t11",  32'(bus.cfg_ack), 32'd0);

    // Start the clock at divider 0 (ready 5 cycles after enable).
    send(2'd0, 7'h11, 7'h22, 1'b1);
    tick(9);
    check("on_en_t10", 32'(bus.clk_enable), 32'd1);
    check_cfg("on_t10", 2'd0, 7'h11, 7'h22);
    tick(22);
    check("on_ack_t32", 32'(bus.cfg_ack), 32'd0);
    tick();
    check("on_ack_t33", 32'(bus.cfg_ack), 32'd1);
    check("on_err_t33", 32'(bus.cfg_err), 32'd0);
    tick();
    check("on_busy_t34", 32'(bus.busy), 32'd0);

    // Running clock, slow gating (12 cycles); switch to divider 3, with a
    // second request during STOP that must be ignored.
    gen_tap  = 11;
    ack_base = ack_cnt;
    send(2'd3, 7'h05, 7'h06, 1'b1);
    check("sw_en_t1", 32'(bus.clk_enable), 32'd0);
    tick(3);
    bus.cfg_mux_ctrl   = 2'd1;
    bus.cfg_drv_phase  = 7'h7F;
    bus.cfg_smpl_phase = 7'h7F;
    bus.cfg_clk_on     = 1'b0;
    bus.cfg_req        = 1'b1;
    tick();
    bus.cfg_req        = 1'b0;
    tick(8);
    check_cfg("sw_t13", 2'd0, 7'h11, 7'h22);
    tick();
    check_cfg("sw_t14", 2'd0, 7'h11, 7'h22);
    check("sw_en_t14", 32'(bus.clk_enable), 32'd0);
    tick();
    check_cfg("sw_t15", 2'd3, 7'h05, 7'h06);
    check("sw_en_t15", 32'(bus.clk_enable), 32'd1);
    tick(27);
    check("sw_ack_t42", 32'(bus.cfg_ack), 32'd0);
    tick();
    check("sw_ack_t43", 32'(bus.cfg_ack), 32'd1);
    check("sw_err_t43", 32'(bus.cfg_err), 32'd0);
    tick(4);
    check("sw_one_ack", 32'(ack_cnt - ack_base), 32'd1);
    check("sw_busy",    32'(bus.busy), 32'd0);
    check_cfg("sw_after", 2'd3, 7'h05, 7'h06);
    gen_tap = 4;

    // clk_ready stuck high: STOP timeout ack at T+1024.
    force_hi = 1'b1;
    send(2'd1, 7'h44, 7'h55, 1'b1);
    tick(1022);
    check("to_ack_t1023",  32'(bus.cfg_ack), 32'd0);
    check("to_busy_t1023", 32'(bus.busy), 32'd1);
    tick();
    check("to_ack_t1024", 32'(bus.cfg_ack), 32'd1);
    check("to_err_t1024", 32'(bus.cfg_err), 32'd1);
    check("to_en_t1024",  32'(bus.clk_enable), 32'd0);
    check_cfg("to_t1024", 2'd3, 7'h05, 7'h06);
    tick();
    check("to_busy_t1025", 32'(bus.busy), 32'd0);
    force_hi = 1'b0;

    // Ready rises in the last START cycle: ready wins, then drops in SETTLE.
    force_lo = 1'b1;
    send(2'd2, 7'h0A, 7'h0B, 1'b1);
    tick(9);
    check("race_en_t10", 32'(bus.clk_enable), 32'd1);
    check_cfg("race_t10", 2'd2, 7'h0A, 7'h0B);
    tick(1022);
    check("race_ack_t1032", 32'(bus.cfg_ack), 32'd0);
    force_lo = 1'b0;
    force_hi = 1'b1;
    tick();
    check("race_ack_t1033", 32'(bus.cfg_ack), 32'd0);
    check("race_en_t1033",  32'(bus.clk_enable), 32'd1);
    tick(2);
    force_hi = 1'b0;
    force_lo = 1'b1;
    tick(12);
    check("race_ack_t1047", 32'(bus.cfg_ack), 32'd0);
    tick();
    check("race_ack_t1048", 32'(bus.cfg_ack), 32'd1);
    check("race_err_t1048", 32'(bus.cfg_err), 32'd0);
    check("race_en_t1048",  32'(bus.clk_enable), 32'd1);
    tick();
    force_lo = 1'b0;
    tick(20);

    // Reset asserted mid-START: outputs clear at once, no ack afterwards.
    send(2'd1, 7'h12, 7'h34, 1'b1);
    tick(11);
    check("rst_pre_en", 32'(bus.clk_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    ack_base = ack_cnt;
    tick(3);
    rst_n = 1'b1;
    tick(40);
    check("rst_no_ack", 32'(ack_cnt - ack_base), 32'd0);
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_en",     32'(bus.clk_enable), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
